// File: rtl/pspl_regbank_pkg.sv
// Shared constants, state types and helpers for the pspl_regbank AXI4-Lite slave.
// Imported by the register bank top level and by its write-channel FSM.
package pspl_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pspl_regbank_wr_fsm.sv
// AXI4-Lite write-channel handshake: captures AW and W independently in either order
// and raises a one-cycle commit strobe, then holds B until the master accepts it.
module pspl_regbank_wr_fsm
  import pspl_regbank_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  output logic            commit,
  output logic [AW-1:0]   commit_addr,
  output logic [DW-1:0]   commit_data,
  output logic [DW/8-1:0] commit_strb,
  input  logic [1:0]      commit_resp,
  output wr_state_t       state
);

  // Handshake rule for every channel: a beat transfers on a rising edge where both
  // valid and ready are high; valid never waits for ready, and ready here is registered.
  logic            aw_held;
  logic            w_held;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;
  logic            aw_fire;
  logic            w_fire;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  // A beat handshaking this edge counts as held, so a same-edge AW+W commits at once.
  assign commit      = (state == WR_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign commit_addr = aw_held ? addr_q : awaddr;
  assign commit_data = w_held ? data_q : wdata;
  assign commit_strb = w_held ? strb_q : wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WR_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (state)
        WR_IDLE: begin
          if (commit) begin
            state   <= WR_RESP;
            bvalid  <= 1'b1;
            bresp   <= commit_resp;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
          end else begin
            if (aw_fire) begin
              aw_held <= 1'b1;
              addr_q  <= awaddr;
              awready <= 1'b0;
            end
            if (w_fire) begin
              w_held <= 1'b1;
              data_q <= wdata;
              strb_q <= wstrb;
              wready <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (bready) begin
            state   <= WR_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pspl_regbank.sv
// Parametrised AXI4-Lite register bank: NUM_CTRL RW control registers driven by the PS
// and NUM_STAT RO status registers driven by the PL, with byte strobes and write pulses.
module pspl_regbank
  import pspl_regbank_pkg::*;
#(
  parameter int                      C_DATA_WIDTH   = 32,
  parameter int                      C_ADDR_WIDTH   = 6,
  parameter int                      NUM_CTRL       = 8,
  parameter int                      NUM_STAT       = 8,
  parameter logic [C_DATA_WIDTH-1:0] CTRL_RESET_VAL = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_CTRL*C_DATA_WIDTH-1:0]   ctrl_o,
  output logic [NUM_CTRL-1:0]                ctrl_wr_pulse_o,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*C_DATA_WIDTH-1:0] stat_i
);

  localparam int DW       = C_DATA_WIDTH;
  localparam int OFF_W    = clog2(DW / 8);
  localparam int IDX_W    = C_ADDR_WIDTH - OFF_W;
  localparam int NUM_REGS = NUM_CTRL + NUM_STAT;

  logic [DW-1:0]           ctrl_q [NUM_CTRL];
  logic [NUM_CTRL-1:0]     pulse_q;

  logic                    wr_commit;
  logic [C_ADDR_WIDTH-1:0] wr_addr;
  logic [DW-1:0]           wr_data;
  logic [DW/8-1:0]         wr_strb;
  logic [1:0]              wr_resp;
  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_is_ctrl;
  logic                    wr_is_stat;
  wr_state_t               wr_state;

  rd_state_t               rd_state;
  logic                    arready_q;
  logic                    rvalid_q;
  logic [DW-1:0]           rdata_q;
  logic [1:0]              rresp_q;
  logic [IDX_W-1:0]        rd_idx;
  logic [DW-1:0]           rd_word;
  logic [1:0]              rd_resp;

  pspl_regbank_wr_fsm #(
    .DW (DW),
    .AW (C_ADDR_WIDTH)
  ) u_wr_fsm (
    .clk         (ACLK),
    .rst         (ARESET),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .bresp       (S_AXI_BRESP),
    .bvalid      (S_AXI_BVALID),
    .bready      (S_AXI_BREADY),
    .commit      (wr_commit),
    .commit_addr (wr_addr),
    .commit_data (wr_data),
    .commit_strb (wr_strb),
    .commit_resp (wr_resp),
    .state       (wr_state)
  );

  // Write decode: status registers refuse writes, anything past them is unmapped.
  assign wr_idx     = wr_addr[C_ADDR_WIDTH-1:OFF_W];
  assign wr_is_ctrl = 32'(wr_idx) < NUM_CTRL;
  assign wr_is_stat = !wr_is_ctrl && (32'(wr_idx) < NUM_REGS);
  assign wr_resp    = wr_is_ctrl ? RESP_OKAY : (wr_is_stat ? RESP_SLVERR : RESP_DECERR);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RESET_VAL;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (wr_commit && wr_is_ctrl) begin
        for (int k = 0; k < NUM_CTRL; k++) begin
          if (32'(wr_idx) == 32'(k)) begin
            pulse_q[k] <= 1'b1;
            for (int b = 0; b < DW / 8; b++) begin
              if (wr_strb[b]) ctrl_q[k][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl
    assign ctrl_o[k*DW +: DW] = ctrl_q[k];
  end
  assign ctrl_wr_pulse_o = pulse_q;

  // Read mux uses the registered ctrl_q, so a same-edge write is not yet visible.
  assign rd_idx = S_AXI_ARADDR[C_ADDR_WIDTH-1:OFF_W];

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_DECERR;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (32'(rd_idx) == 32'(k)) begin
        rd_word = ctrl_q[k];
        rd_resp = RESP_OKAY;
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (32'(rd_idx) == 32'(NUM_CTRL + k)) begin
        rd_word = stat_i[k*DW +: DW];
        rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state  <= RD_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            rd_state  <= RD_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
            rresp_q   <= rd_resp;
          end
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  // Protection bits and sub-word address bits carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[OFF_W-1:0],
                       wr_addr[OFF_W-1:0], wr_state};

endmodule
